// File: rtl/road_pos_counter.sv
`default_nettype none
// ============================================================================
// road_pos_counter : step-aligned road position counter with clamp/wrap bounds
// Revision 1.0
// ============================================================================
module road_pos_counter #(
   parameter int WIDTH      = 16,
   parameter int STEP_SHIFT = 1,
   parameter int MIN_POS    = 0,
   parameter int MAX_POS    = 638,
   parameter int FRAME_DIV  = 1,
   parameter int WRAP_MODE  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame,
   input  logic             L,
   input  logic             R,
   input  logic             rollover,
   input  logic [3:0]       speed,
   input  logic [WIDTH-1:0] init_pos,
   input  logic [WIDTH-1:0] reset_pos,
   output logic [WIDTH-1:0] pos,
   output logic             at_min,
   output logic             at_max,
   output logic             edge_hit
);

   localparam int C_EXT   = WIDTH + 2;
   localparam int C_DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   localparam logic [C_DIV_W-1:0]      C_DIV_LAST   = C_DIV_W'(FRAME_DIV - 1);
   localparam logic [WIDTH-1:0]        C_MIN        = WIDTH'(MIN_POS);
   localparam logic [WIDTH-1:0]        C_MAX        = WIDTH'(MAX_POS);
   localparam logic [WIDTH-1:0]        C_ALIGN_MASK = ~(WIDTH'((1 << STEP_SHIFT) - 1));
   localparam logic signed [C_EXT-1:0] C_MIN_S      = C_EXT'(MIN_POS);
   localparam logic signed [C_EXT-1:0] C_MAX_S      = C_EXT'(MAX_POS);
   localparam logic signed [C_EXT-1:0] C_SPAN_S     = C_EXT'(MAX_POS - MIN_POS + (1 << STEP_SHIFT));

   logic [WIDTH-1:0]        pos_q, pos_d;
   logic [C_DIV_W-1:0]      div_q, div_d;
   logic                    edge_q, edge_d;
   logic                    w_tick;
   logic                    w_move;
   logic signed [C_EXT-1:0] w_base;
   logic signed [C_EXT-1:0] w_delta;
   logic signed [C_EXT-1:0] w_sum;

   // Loaded values are forced onto the step grid before being bounded.
   function automatic logic [WIDTH-1:0] load_fix(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] a;
      a = v & C_ALIGN_MASK;
      if (a < C_MIN)
         load_fix = C_MIN;
      else if (a > C_MAX)
         load_fix = C_MAX;
      else
         load_fix = a;
   endfunction

   always_comb begin
      w_base  = $signed({2'b00, pos_q});
      w_delta = $signed({{(C_EXT-4){1'b0}}, speed}) <<< STEP_SHIFT;
      w_sum   = L ? (w_base - w_delta) : (w_base + w_delta);
      w_tick  = frame && (div_q == C_DIV_LAST);
      w_move  = w_tick && (L ^ R) && (speed != 4'd0);
   end

   always_comb begin
      pos_d  = pos_q;
      div_d  = div_q;
      edge_d = 1'b0;
      if (rollover) begin
         pos_d = load_fix(reset_pos);
         div_d = '0;
      end else if (frame) begin
         div_d = w_tick ? '0 : div_q + 1'b1;
         if (w_move) begin
            if (w_sum > C_MAX_S) begin
               edge_d = 1'b1;
               pos_d  = (WRAP_MODE != 0) ? WIDTH'(w_sum - C_SPAN_S) : C_MAX;
            end else if (w_sum < C_MIN_S) begin
               edge_d = 1'b1;
               pos_d  = (WRAP_MODE != 0) ? WIDTH'(w_sum + C_SPAN_S) : C_MIN;
            end else begin
               pos_d  = WIDTH'(w_sum);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q  <= load_fix(init_pos);
         div_q  <= '0;
         edge_q <= 1'b0;
      end else begin
         pos_q  <= pos_d;
         div_q  <= div_d;
         edge_q <= edge_d;
      end
   end

   assign pos      = pos_q;
   assign at_min   = (pos_q == C_MIN);
   assign at_max   = (pos_q == C_MAX);
   assign edge_hit = edge_q;

endmodule
`default_nettype wire
